// File: rtl/fetch_ctrl_pkg.sv
// Shared types and sizing for the fetch controller: packet layout, fetch width
// and controller state encoding.
package fetch_ctrl_pkg;

  localparam int N               = 3;
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } FETCH_PACKET;

  typedef enum logic [1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_SQUASH = 2'd2
  } FETCH_STATE;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one block request at a time to the icache and turns
// the response into N fetch packets, squashing responses made stale by a redirect.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            restore_valid,
  input  logic [31:0]                     restore_pc,
  input  logic [NUM_SCALAR_BITS-1:0]      inst_buffer_spots,
  output logic                            icache_req_valid,
  output logic [31:0]                     icache_req_addr,
  input  logic                            icache_req_ready,
  input  logic                            icache_rsp_valid,
  input  logic [N-1:0][31:0]              icache_rsp_data,
  output FETCH_PACKET [N-1:0]             inst_buffer_inputs,
  output logic [NUM_SCALAR_BITS-1:0]      inst_valid
);

  localparam logic [NUM_SCALAR_BITS-1:0] FULL_COUNT = NUM_SCALAR_BITS'(N);
  localparam logic [31:0]                BLOCK_BYTES = 32'(4 * N);

  FETCH_STATE  state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] restore_aligned;
  logic        deliver;

  assign restore_aligned = restore_pc & ~32'd3;

  // Only issue when the whole block fits in the buffer; gating with reset keeps
  // the outputs quiet while reset is held.
  assign icache_req_valid = !reset && (state_reg == FETCH_REQ) &&
                            (inst_buffer_spots == FULL_COUNT) && !restore_valid;
  assign icache_req_addr  = fetch_pc_reg;

  assign deliver    = !reset && (state_reg == FETCH_WAIT) && icache_rsp_valid && !restore_valid;
  assign inst_valid = deliver ? FULL_COUNT : '0;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    case (state_reg)
      FETCH_REQ: begin
        if (restore_valid) begin
          fetch_pc_next = restore_aligned;
        end else if (icache_req_valid && icache_req_ready) begin
          state_next = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (restore_valid) begin
          fetch_pc_next = restore_aligned;
          state_next    = icache_rsp_valid ? FETCH_REQ : FETCH_SQUASH;
        end else if (icache_rsp_valid) begin
          fetch_pc_next = fetch_pc_reg + BLOCK_BYTES;
          state_next    = FETCH_REQ;
        end
      end
      FETCH_SQUASH: begin
        if (restore_valid) begin
          fetch_pc_next = restore_aligned;
        end
        if (icache_rsp_valid) begin
          state_next = FETCH_REQ;
        end
      end
      default: begin
        state_next = FETCH_REQ;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= FETCH_REQ;
      fetch_pc_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  // Unused packet slots are zeroed so downstream never sees leftover data.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pkt
      logic [31:0] slot_pc;
      assign slot_pc = fetch_pc_reg + 32'(4 * gi);
      assign inst_buffer_inputs[gi] = deliver ?
          FETCH_PACKET'{inst: icache_rsp_data[gi], pc: slot_pc, npc: slot_pc + 32'd4} :
          FETCH_PACKET'('0);
    end
  endgenerate

  // A response with nothing outstanding means the icache broke the protocol.
  a_no_rsp_in_req: assert property (@(posedge clock) disable iff (reset)
      !(state_reg == FETCH_REQ && icache_rsp_valid));

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Ports, clock and reset first:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- restore_valid  input  1  branch-stack redirect.
- restore_pc  input  32  redirect target.
- inst_buffer_spots  input  `NUM_SCALAR_BITS  free inst-buffer slots, saturated at `N.
- icache_req_valid  output  1  fetch request.
- icache_req_addr  output  32  word-aligned block start PC.
- icache_req_ready  input  1  icache accepts the request this cycle.
- icache_rsp_valid  input  1  response data valid.
- icache_rsp_data  input  `N x 32  instructions at addr, addr+4, ...
- inst_buffer_inputs  output  FETCH_PACKET[`N]  packets to the inst buffer.
- inst_valid  output  `NUM_SCALAR_BITS  count of valid packets this cycle.
REQ-002 One clock; reset is synchronous and active-high.

Function
REQ-003 States: REQ (may issue), WAIT (one request outstanding), SQUASH (outstanding response is stale).
REQ-004 At most one request is outstanding at any time.
REQ-005 In REQ, icache_req_valid = 1 iff inst_buffer_spots == `N and restore_valid == 0.
- icache_req_addr = fetch_pc.
REQ-006 A request is accepted when icache_req_valid && icache_req_ready.
- On acceptance: REQ -> WAIT next cycle.
- Without acceptance: stay in REQ with fetch_pc unchanged.
REQ-007 In WAIT with icache_rsp_valid and no restore:
- inst_valid = `N in the same cycle (combinational pass-through).
- Packet i: inst = icache_rsp_data[i], PC = fetch_pc + 4i, NPC = PC + 4.
- fetch_pc <= fetch_pc + 4*`N; state -> REQ.
REQ-008 In WAIT without a response: stay in WAIT; inst_valid = 0.
REQ-009 Packets at index >= inst_valid are driven as all zeros.
REQ-010 inst_valid is 0 in every cycle in which restore_valid = 1, whatever the state.
REQ-011 Restore in REQ:
- fetch_pc <= restore_pc.
- No request is driven that cycle; stay in REQ.
REQ-012 Restore in WAIT:
- With icache_rsp_valid in the same cycle: drop the response, fetch_pc <= restore_pc, state -> REQ.
- Otherwise: fetch_pc <= restore_pc, state -> SQUASH.
REQ-013 In SQUASH:
- icache_req_valid = 0 and inst_valid = 0.
- The next icache_rsp_valid is discarded; state -> REQ.
- A further restore while in SQUASH only updates fetch_pc.
REQ-014 A response that arrives in state REQ is a protocol error: it is ignored and an assertion fires.
REQ-015 fetch_pc arithmetic is modulo 2^32.
- restore_pc[1:0] is forced to 0 when loaded.

Reset
REQ-016 Reset values:
- fetch_pc = 0, state = REQ.
- icache_req_valid = 0, inst_valid = 0, inst_buffer_inputs = 0.
REQ-017 Reset has priority over restore_valid and over any response.
- Reset in WAIT or SQUASH discards the outstanding transaction.
- The first request is issued in the first cycle after reset deasserts.

Structure
REQ-018 The shared package holds: FETCH_PACKET (inst, PC, NPC), `N, `NUM_SCALAR_BITS, and the FETCH_STATE enum.
REQ-019 The block is a single module with no sub-modules.
- Packet formation is a generate loop over `N.

Verification (`N = 3)
REQ-020 Reset, then spots = 3, ready = 1:
- Request at addr 0x0 in cycle 1.
- Response in cycle 3 -> inst_valid = 3, PCs 0x0/0x4/0x8.
- Next request at addr 0xC.
REQ-021 spots = 2:
- icache_req_valid stays 0.
- When spots becomes 3, a request at the current PC is issued in that same cycle.
REQ-022 Request at 0x18 accepted, then restore_pc = 0x100 during WAIT with no response:
- State -> SQUASH.
- The next response is dropped with inst_valid = 0.
- Next request at addr 0x100.
REQ-023 Response and restore (restore_pc = 0x40) in the same WAIT cycle:
- inst_valid = 0.
- Next cycle: request at addr 0x40.
REQ-024 Reset asserted during WAIT, with a response in the following cycle:
- Response ignored.
- Request at 0x0 in the first cycle after reset deasserts.
REQ-025 fetch_pc = 0xFFFFFFF4, one full fetch:
- Packet PCs 0xFFFFFFF4/0xFFFFFFF8/0xFFFFFFFC.
- Next request at addr 0x0.
